// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Turns the byte stream of an SPI slave byte engine into accesses on a
// simple synchronous register port. The first byte of a frame is a command
// (bit7 = read, low bits = start address). Then either write data follows,
// with one register write per byte, or the register contents are streamed
// back with an auto-incrementing address. Frames are delimited by slave
// select.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ss         raw slave select, active low, asynchronous to clk
//   byte_done  one-cycle pulse from the byte engine: a byte completed
//   rx_byte    received byte, valid with byte_done
//   tx_byte    byte loaded by the engine at the next byte boundary
//   reg_addr   register address
//   reg_wdata  register write data
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe
//   reg_rdata  read data, valid exactly one cycle after reg_re
//   busy       high while a frame is being decoded or serviced
//   frame_done one-cycle pulse when an active frame ends
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] IDLE_BYTE = 8'h4E,
    parameter logic [7:0] TURN_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              byte_done,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        WAIT_SS = 3'd0,
        IDLE    = 3'd1,
        CMD     = 3'd2,
        RD_TURN = 3'd3,
        RD_DATA = 3'd4,
        WR_DATA = 3'd5
    } state_t;

    state_t state_reg, state_next;

    // Two-flop synchronizer for the asynchronous slave select.
    logic ss_meta_reg, ss_s_reg;

    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic [7:0]        tx_reg, tx_next;
    logic              we_reg, we_next;
    logic              re_reg, re_next;
    logic              rd_valid_reg;     // reg_rdata is valid this cycle
    logic              frame_done_reg, frame_done_next;
    logic              active;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_meta_reg <= 1'b0;
            ss_s_reg    <= 1'b0;
        end else begin
            ss_meta_reg <= ss;
            ss_s_reg    <= ss_meta_reg;
        end
    end

    assign active = (state_reg == CMD) || (state_reg == RD_TURN) ||
                    (state_reg == RD_DATA) || (state_reg == WR_DATA);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WAIT_SS;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_SS: if (ss_s_reg) state_next = IDLE;
            IDLE:    if (!ss_s_reg) state_next = CMD;
            CMD: begin
                if (ss_s_reg) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = rx_byte[7] ? RD_TURN : WR_DATA;
                end
            end
            RD_TURN: begin
                if (ss_s_reg) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA, WR_DATA: if (ss_s_reg) state_next = IDLE;
            default: state_next = WAIT_SS;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        we_next         = 1'b0;
        re_next         = 1'b0;
        tx_next         = tx_reg;
        frame_done_next = 1'b0;

        // The write address advances in the cycle after its strobe, so the
        // strobe itself still presents the address the byte belongs to.
        if (we_reg) begin
            addr_next = addr_reg + ADDR_W'(1);
        end

        case (state_reg)
            CMD: begin
                // A read command fetches the start address straight away so
                // the data is ready for the byte after the turnaround byte.
                if (byte_done && !ss_s_reg) begin
                    addr_next = rx_byte[ADDR_W-1:0];
                    re_next   = rx_byte[7];
                end
            end
            RD_TURN, RD_DATA: begin
                // Prefetch: each completed byte fetches the next register.
                if (byte_done && !ss_s_reg) begin
                    addr_next = addr_reg + ADDR_W'(1);
                    re_next   = 1'b1;
                end
            end
            WR_DATA: begin
                // A byte finishing together with deselect is still written.
                if (byte_done) begin
                    we_next    = 1'b1;
                    wdata_next = rx_byte;
                end
            end
            default: ;
        endcase

        if (active && ss_s_reg) begin
            frame_done_next = 1'b1;
        end

        // Leaving a frame discards any in-flight read data.
        case (state_next)
            RD_TURN, RD_DATA: if (rd_valid_reg) tx_next = reg_rdata;
            CMD, WR_DATA:     tx_next = TURN_BYTE;
            default:          tx_next = IDLE_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg       <= '0;
            wdata_reg      <= 8'h00;
            tx_reg         <= IDLE_BYTE;
            we_reg         <= 1'b0;
            re_reg         <= 1'b0;
            rd_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            tx_reg         <= tx_next;
            we_reg         <= we_next;
            re_reg         <= re_next;
            rd_valid_reg   <= re_reg;
            frame_done_reg <= frame_done_next;
        end
    end

    assign tx_byte    = tx_reg;
    assign reg_addr   = addr_reg;
    assign reg_wdata  = wdata_reg;
    assign reg_we     = we_reg;
    assign reg_re     = re_reg;
    assign busy       = active;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
//
// Drives whole SPI frames at the byte level, the way the slave byte engine
// would. The bench holds a register bank that answers the DUT's register
// port. Expected MISO bytes and register strobes come from constant vectors
// and from a frame-level model: an array of what the registers should hold.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    localparam int BYTE_CLK = 36;   // clk cycles per SPI byte

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss = 1'b1;
    logic       byte_done = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_done;

    spi_reg_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .byte_done  (byte_done),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Register bank on the far side: data appears exactly one cycle after
    // reg_re and reads as 0xEE in any other cycle.
    logic [7:0] bank [0:127];
    logic [7:0] bank_q = 8'h00;
    logic       bank_v = 1'b0;
    always @(posedge clk) begin
        bank_v <= reg_re;
        if (reg_re) bank_q <= bank[reg_addr];
        if (reg_we) bank[reg_addr] <= reg_wdata;
    end
    assign reg_rdata = bank_v ? bank_q : 8'hEE;

    // Strobe monitor
    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } strobe_t;

    strobe_t log_q[$];
    int      fd_count = 0;
    int      both_count = 0;
    always @(negedge clk) begin
        if (reg_we) log_q.push_back({1'b1, reg_addr, reg_wdata});
        if (reg_re) log_q.push_back({1'b0, reg_addr, 8'h00});
        if (frame_done) fd_count++;
        if (reg_we && reg_re) both_count++;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Frame buffers shared by the frame driver and the checkers
    logic [7:0] fmosi [0:135];
    logic [7:0] fmiso [0:135];
    logic [7:0] ref_mem [0:127];

    // Drive one frame of n bytes. MISO byte 0 is what the engine holds while
    // deselected; byte k+1 is what tx_byte shows when byte k completes.
    task automatic run_frame(input int n);
        @(negedge clk);
        fmiso[0] = tx_byte;
        ss = 1'b0;
        for (int k = 0; k < n; k++) begin
            repeat (BYTE_CLK - 1) @(negedge clk);
            byte_done = 1'b1;
            rx_byte   = fmosi[k];
            if (k + 1 < 136) fmiso[k + 1] = tx_byte;
            @(negedge clk);
            byte_done = 1'b0;
        end
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // What the master should receive in byte k of the current frame
    function automatic logic [7:0] model_miso(input int k);
        if (k == 0) return 8'h4E;
        if (k == 1) return 8'hA5;
        if (fmosi[0][7]) return ref_mem[(int'(fmosi[0][6:0]) + k - 2) % 128];
        return 8'hA5;
    endfunction

    // A read frame of n bytes produces n reads from consecutive addresses
    // (start, turnaround, then one per data byte); a write frame produces
    // n-1 writes. Exactly one frame_done pulse per frame.
    task automatic check_strobes(input string tag, input int n, input int log_base, input int fd_base);
        logic [7:0] cmd;
        int         a;
        int         exp_cnt;
        strobe_t    e;
        cmd = fmosi[0];
        a = int'(cmd[6:0]);
        exp_cnt = cmd[7] ? n : n - 1;
        check({tag, " strobe count"}, log_q.size() - log_base, exp_cnt);
        for (int i = 0; i < exp_cnt && log_base + i < log_q.size(); i++) begin
            e.we   = ~cmd[7];
            e.addr = 7'((a + i) % 128);
            e.data = cmd[7] ? 8'h00 : fmosi[i + 1];
            check({tag, " strobe"}, 32'(log_q[log_base + i]), 32'(e));
        end
        if (!cmd[7]) begin
            for (int i = 0; i < exp_cnt; i++) ref_mem[(a + i) % 128] = fmosi[i + 1];
        end
        check({tag, " frame_done pulses"}, fd_count - fd_base, 1);
        check({tag, " re/we overlap"}, both_count, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_byte"}, tx_byte, 8'h4E);
        check({tag, " reg_addr"}, reg_addr, 7'h00);
        check({tag, " reg_wdata"}, reg_wdata, 8'h00);
        check({tag, " reg_we"}, reg_we, 1'b0);
        check({tag, " reg_re"}, reg_re, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " frame_done"}, frame_done, 1'b0);
    endtask

    typedef struct packed {
        logic [3:0]  n;
        logic [47:0] mosi;   // byte k at [8k+7:8k]
        logic [47:0] miso;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int lb;
        int fb;
        int n;

        vecs[0] = '{n: 4'd4, mosi: 48'h0000_3322_1105, miso: 48'h0000_A5A5_A54E};
        vecs[1] = '{n: 4'd5, mosi: 48'h00C3_C2C1_C005, miso: 48'h00A5_A5A5_A54E};
        vecs[2] = '{n: 4'd6, mosi: 48'h0000_0000_0085, miso: 48'hC3C2_C1C0_A54E};
        vecs[3] = '{n: 4'd4, mosi: 48'h0000_9C9B_9A7E, miso: 48'h0000_A5A5_A54E};
        vecs[4] = '{n: 4'd5, mosi: 48'h0000_0000_00FE, miso: 48'h009C_9B9A_A54E};

        // Reset with ss low; bytes clocked before the first deselect are ignored
        ss  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        lb = log_q.size();
        fb = fd_count;
        for (int k = 0; k < 2; k++) begin
            repeat (BYTE_CLK - 1) @(negedge clk);
            byte_done = 1'b1;
            rx_byte   = (k == 0) ? 8'h05 : 8'h11;
            @(negedge clk);
            byte_done = 1'b0;
        end
        check("wait_ss busy", busy, 1'b0);
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        check("wait_ss strobes", log_q.size() - lb, 0);
        check("wait_ss frame_done", fd_count - fb, 0);
        check("idle tx_byte", tx_byte, 8'h4E);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < int'(vecs[i].n); k++) fmosi[k] = vecs[i].mosi[8*k +: 8];
            lb = log_q.size();
            fb = fd_count;
            run_frame(int'(vecs[i].n));
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                check($sformatf("vec%0d miso[%0d]", i, k), fmiso[k], vecs[i].miso[8*k +: 8]);
            end
            check_strobes($sformatf("vec%0d", i), int'(vecs[i].n), lb, fb);
        end

        // Deselect right after the command byte
        fmosi[0] = 8'h10;
        lb = log_q.size();
        fb = fd_count;
        run_frame(1);
        check("cmd-only strobes", log_q.size() - lb, 0);
        check("cmd-only frame_done", fd_count - fb, 1);
        check("cmd-only busy", busy, 1'b0);
        check("cmd-only tx_byte", tx_byte, 8'h4E);

        // Last byte completes in the same cycle the deselect is detected
        lb = log_q.size();
        fb = fd_count;
        @(negedge clk);
        ss = 1'b0;
        repeat (BYTE_CLK) @(negedge clk);
        byte_done = 1'b1;
        rx_byte   = 8'h20;
        @(negedge clk);
        byte_done = 1'b0;
        repeat (BYTE_CLK - 2) @(negedge clk);
        ss = 1'b1;
        repeat (2) @(negedge clk);
        byte_done = 1'b1;
        rx_byte   = 8'h5A;
        @(negedge clk);
        byte_done = 1'b0;
        check("coincident reg_we", reg_we, 1'b1);
        check("coincident reg_addr", reg_addr, 7'h20);
        check("coincident reg_wdata", reg_wdata, 8'h5A);
        check("coincident frame_done", frame_done, 1'b1);
        check("coincident busy", busy, 1'b0);
        repeat (8) @(negedge clk);
        check("coincident strobes", log_q.size() - lb, 1);
        check("coincident frame_done pulses", fd_count - fb, 1);
        ref_mem[8'h20] = 8'h5A;

        // Reset pulsed in the middle of a write data byte
        lb = log_q.size();
        fb = fd_count;
        @(negedge clk);
        ss = 1'b0;
        for (int k = 0; k < 2; k++) begin
            repeat (BYTE_CLK - 1) @(negedge clk);
            byte_done = 1'b1;
            rx_byte   = (k == 0) ? 8'h30 : 8'h77;
            @(negedge clk);
            byte_done = 1'b0;
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midframe reset");
        repeat (BYTE_CLK - 12) @(negedge clk);
        byte_done = 1'b1;
        rx_byte   = 8'h88;
        @(negedge clk);
        byte_done = 1'b0;
        repeat (4) @(negedge clk);
        check("midframe reset busy", busy, 1'b0);
        check("midframe reset reg_we", reg_we, 1'b0);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        check("midframe reset strobes", log_q.size() - lb, 1);
        if (log_q.size() > lb) check("midframe reset write", 32'(log_q[lb]), 32'({1'b1, 7'h30, 8'h77}));
        check("midframe reset frame_done", fd_count - fb, 0);
        ref_mem[8'h30] = 8'h77;

        // Fill the whole bank with random data, wrapping from 0x7F to 0x00
        fmosi[0] = 8'h00;
        for (int k = 1; k <= 128; k++) fmosi[k] = 8'($urandom);
        lb = log_q.size();
        fb = fd_count;
        run_frame(129);
        for (int k = 0; k < 129; k++) check($sformatf("fill miso[%0d]", k), fmiso[k], model_miso(k));
        check_strobes("fill", 129, lb, fb);

        // Random frames against the model
        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(1, 7));
            fmosi[0][7]   = 1'($urandom_range(0, 1));
            fmosi[0][6:0] = (r % 3 == 0) ? 7'(8'h7C + $urandom_range(0, 3)) : 7'($urandom_range(0, 127));
            for (int k = 1; k < n; k++) fmosi[k] = 8'($urandom);
            lb = log_q.size();
            fb = fd_count;
            run_frame(n);
            $display("rand frame %0d: cmd 0x%02h, %0d bytes", r, fmosi[0], n);
            for (int k = 0; k < n; k++) check($sformatf("rand%0d miso[%0d]", r, k), fmiso[k], model_miso(k));
            check_strobes($sformatf("rand%0d", r), n, lb, fb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Transaction controller that sits behind the SPI slave byte engine and turns its byte stream into register-bank accesses. It decodes a command byte, sequences auto-incrementing reads or writes on a simple synchronous register port, and feeds the slave's transmit byte in time for each byte boundary. Frames are delimited by slave select; the register bank (iCE40 BRAM or flops) sits on the far side.

## Interface
Parameters:
- ADDR_W, 7: register address width, 1..7; address field is cmd[ADDR_W-1:0].
- IDLE_BYTE, 8'h4E: first byte shifted out in every frame.
- TURN_BYTE, 8'hA5: byte shifted out during command/turnaround and during write data bytes.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ss  in  1  raw SPI slave select (active low), asynchronous to clk.
- byte_done  in  1  one-cycle pulse from the byte engine: a byte completed.
- rx_byte  in  8  received byte; valid in the byte_done cycle.
- tx_byte  out  8  byte the engine loads at the next byte boundary (and continuously while deselected).
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly one cycle after reg_re.
- busy  out  1  high in CMD, RD_TURN, RD_DATA, WR_DATA.
- frame_done  out  1  one-cycle pulse when an active frame ends.

## Operation
- ss passes a 2-flop synchronizer (reset to 0); ss_s is the output. ss_rise = ss_s high and previous ss_s low.
- Command byte: bit7 = 1 read, 0 write; bits[ADDR_W-1:0] = start address; unused bits ignored.
- States:
  - WAIT_SS (reset state): ignore byte_done; go IDLE when ss_s = 1. Frames in progress at reset release are discarded.
  - IDLE: tx_byte = IDLE_BYTE; go CMD when ss_s = 0.
  - CMD: tx_byte = TURN_BYTE; on byte_done latch addr = rx_byte[ADDR_W-1:0]; go RD_TURN if bit7 else WR_DATA.
  - RD_TURN: on entry issue reg_re at addr; capture reg_rdata into tx_byte. On byte_done (turnaround byte, contents ignored; the master received TURN_BYTE) go RD_DATA, addr += 1, issue prefetch.
  - RD_DATA: each byte_done: addr += 1, reg_re at new addr, tx_byte <= reg_rdata. Master receives mem[A], mem[A+1], ... from byte 2 onward.
  - WR_DATA: tx_byte = TURN_BYTE. Each byte_done: next cycle reg_we = 1, reg_addr = addr, reg_wdata = rx_byte; then addr += 1.
- Any active state: ss_s = 1 goes IDLE with frame_done pulse; in-flight read data is discarded and tx_byte returns to IDLE_BYTE.
- Address arithmetic modulo 2^ADDR_W: 0x7F + 1 wraps to 0x00 (ADDR_W = 7).
- reg_re and reg_we never assert in the same cycle; neither asserts in WAIT_SS or IDLE.

## Timing
- Reset values: tx_byte = IDLE_BYTE, reg_addr = 0, reg_wdata = 0, reg_we = 0, reg_re = 0, busy = 0, frame_done = 0, state WAIT_SS.
- ss fall to CMD: 3 clk (2 sync + 1 state).
- byte_done at cycle t: reg_re or reg_we at t+1; reg_rdata at t+2; tx_byte updated by t+3 edge.
- Requirement on the link: SCK period ≥ 4 clk, so tx_byte is stable ≥ 20 clk before the next byte boundary.
- byte_done coincident with ss_rise detection: byte processed (write strobe still issued at t+1), state goes IDLE, frame_done pulses at t+1.
- rst asserted mid-frame: all outputs to reset values next edge; no strobe issued for the pending byte.

## Test plan
- Reset with ss low, clock 2 bytes, raise ss -> no reg_we/reg_re; IDLE reached; next frame works.
- Write frame 0x05, 0x11, 0x22, 0x33 -> reg_we three times: addr 0x05/0x06/0x07, data 0x11/0x22/0x33; MISO bytes 0x4E, 0xA5, 0xA5, 0xA5.
- Read frame 0x85, dummy, 4 dummies with mem[5..8] = 0xC0..0xC3 -> MISO 0x4E, 0xA5, 0xC0, 0xC1, 0xC2, 0xC3.
- Read from 0x7E for 3 data bytes -> reg_addr sequence 0x7E, 0x7F, 0x00; data mem[0x7E], mem[0x7F], mem[0x00].
- ss raised after the command byte only -> frame_done one pulse, busy low, tx_byte = 0x4E, no strobes.
- rst pulsed during WR_DATA mid-byte -> no write for that byte, outputs at reset values, WAIT_SS until ss high.
